// File: rtl/hog_mon_pkg.sv
// Shared encodings for the HOG performance monitor: FSM states, read selects,
// command bit positions and the version word.
package hog_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned NUM_CNT = 7;
  localparam int unsigned SEL_W   = 3;

  localparam logic [SEL_W-1:0] SEL_CYCLES    = 3'd0;
  localparam logic [SEL_W-1:0] SEL_IN_BEATS  = 3'd1;
  localparam logic [SEL_W-1:0] SEL_IN_STALL  = 3'd2;
  localparam logic [SEL_W-1:0] SEL_IN_STARVE = 3'd3;
  localparam logic [SEL_W-1:0] SEL_HOG_FIRE  = 3'd4;
  localparam logic [SEL_W-1:0] SEL_OUT_BEATS = 3'd5;
  localparam logic [SEL_W-1:0] SEL_OUT_STALL = 3'd6;
  localparam logic [SEL_W-1:0] SEL_VERSION   = 3'd7;

  localparam int unsigned CMD_START   = 0;
  localparam int unsigned CMD_STOP    = 1;
  localparam int unsigned CMD_CLEAR   = 2;
  localparam int unsigned CMD_SEL_LSB = 4;

  localparam logic [31:0] HOG_MON_VERSION = 32'h484D_0001;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clear wins over count.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/hog_perf_monitor.sv
// Measurement window controller for the HOG pipeline handshakes: arms on an HPS
// command, counts beats/stalls/starvation over one window, freezes and reads back.
module hog_perf_monitor
  import hog_mon_pkg::*;
#(
  parameter int unsigned LEVELS        = 7,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned WINDOW_CYCLES = 50_000_000,
  parameter logic [31:0] VERSION       = HOG_MON_VERSION
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cmd_pio,
  input  logic              hog_input_valid,
  input  logic              hog_input_ready,
  input  logic [LEVELS-1:0] hog_out_valid,
  input  logic [LEVELS-1:0] hog_out_ready,
  input  logic              switch_out_valid,
  input  logic              switch_out_ready,
  output logic [31:0]       status_pio,
  output logic [31:0]       data_pio,
  output logic              busy
);

  localparam int unsigned CMD_W = CMD_CLEAR + 1;

  logic [CMD_W-1:0] cmd_r_q,  cmd_r_d;
  logic [CMD_W-1:0] cmd_r2_q, cmd_r2_d;
  logic [SEL_W-1:0] sel_q,    sel_d;
  state_e           state_q,  state_d;
  logic             window_done_q, window_done_d;
  logic [31:0]      data_pio_q, data_pio_d;

  logic [CMD_W-1:0] pulse_c;
  logic             clear_c, stop_c, start_c;
  logic             in_fire_c, last_c;
  logic             count_en_c, cnt_clr_c;
  logic [NUM_CNT-1:0] ev_c, cnt_en_c;
  logic [CNT_W-1:0] cnt_val [NUM_CNT];
  logic             unused_cmd_c;

  assign unused_cmd_c = ^{cmd_pio[31:CMD_SEL_LSB+SEL_W], cmd_pio[CMD_SEL_LSB-1:CMD_W]};

  // Two-stage command capture; only rising edges act, resolved clear > stop > start
  always_comb begin
    cmd_r_d  = cmd_pio[CMD_W-1:0];
    cmd_r2_d = cmd_r_q;
    sel_d    = cmd_pio[CMD_SEL_LSB +: SEL_W];
    pulse_c  = cmd_r_q & ~cmd_r2_q;
    clear_c  = pulse_c[CMD_CLEAR];
    stop_c   = pulse_c[CMD_STOP]  & ~pulse_c[CMD_CLEAR];
    start_c  = pulse_c[CMD_START] & ~pulse_c[CMD_STOP] & ~pulse_c[CMD_CLEAR];
  end

  assign in_fire_c = hog_input_valid & hog_input_ready;
  // The counted cycle that brings the cycle counter to the window length is the last one
  assign last_c    = (32'(cnt_val[SEL_CYCLES]) == 32'(WINDOW_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_c) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start_c) state_d = ST_ARMED;
        ST_ARMED: begin
          if (stop_c) begin
            state_d = ST_IDLE;
          end else if (in_fire_c) begin
            state_d = last_c ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: if (stop_c || last_c) state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Counter control, window_done and the status word
  always_comb begin
    count_en_c = !clear_c &&
                 ((state_q == ST_RUN) || ((state_q == ST_ARMED) && in_fire_c && !stop_c));
    cnt_clr_c  = clear_c || (start_c && ((state_q == ST_IDLE) || (state_q == ST_DONE)));
    window_done_d = window_done_q;
    if (cnt_clr_c) begin
      window_done_d = 1'b0;
    end else if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
      window_done_d = 1'b1;
    end
    busy       = (state_q == ST_ARMED) || (state_q == ST_RUN);
    status_pio = {28'd0, window_done_q, busy, state_q};
  end

  always_comb begin
    ev_c                = '0;
    ev_c[SEL_CYCLES]    = 1'b1;
    ev_c[SEL_IN_BEATS]  = hog_input_valid & hog_input_ready;
    ev_c[SEL_IN_STALL]  = hog_input_valid & ~hog_input_ready;
    ev_c[SEL_IN_STARVE] = hog_input_ready & ~hog_input_valid;
    ev_c[SEL_HOG_FIRE]  = |(hog_out_valid & hog_out_ready);
    ev_c[SEL_OUT_BEATS] = switch_out_valid & switch_out_ready;
    ev_c[SEL_OUT_STALL] = switch_out_valid & ~switch_out_ready;
    cnt_en_c            = ev_c & {NUM_CNT{count_en_c}};
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr_c),
      .en  (cnt_en_c[i]),
      .q   (cnt_val[i])
    );
  end

  always_comb begin
    data_pio_d = VERSION;
    if (sel_q != SEL_VERSION) begin
      data_pio_d = 32'(cnt_val[sel_q]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_r_q       <= '0;
      cmd_r2_q      <= '0;
      sel_q         <= '0;
      window_done_q <= 1'b0;
      data_pio_q    <= '0;
    end else begin
      cmd_r_q       <= cmd_r_d;
      cmd_r2_q      <= cmd_r2_d;
      sel_q         <= sel_d;
      window_done_q <= window_done_d;
      data_pio_q    <= data_pio_d;
    end
  end

  assign data_pio = data_pio_q;

endmodule

// File: tb/tb_hog_perf_monitor.sv
// Self-checking bench for hog_perf_monitor: table-driven windows, hand-written
// command corner cases and random windows against a window-range reference model.
module tb_hog_perf_monitor;

  localparam int N = 140;
  localparam int W = 100;
  localparam logic [31:0] VER     = 32'h484D_0001;
  localparam logic [31:0] C_START = 32'h1;
  localparam logic [31:0] C_STOP  = 32'h2;
  localparam logic [31:0] C_CLEAR = 32'h4;

  localparam int M_FULL = 0, M_ALT = 1, M_SWSTALL = 2, M_NONE = 3, M_HOG = 4,
                 M_STARVE = 5, M_RAND = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd_pio;
  logic        hog_input_valid, hog_input_ready;
  logic [6:0]  hog_out_valid, hog_out_ready;
  logic        switch_out_valid, switch_out_ready;
  logic [31:0] status_pio, data_pio, status2, data2;
  logic        busy, busy2;

  int total = 0;
  int bad   = 0;

  logic       tr_iv [N], tr_ir [N], tr_sv [N], tr_sr [N];
  logic [6:0] tr_hv [N], tr_hr [N];

  typedef struct {
    int               mode;
    int               ff;
    int               stop_at;
    logic [3:0]       early;
    logic [3:0]       st;
    logic [6:0][31:0] exp;
  } vec_t;

  vec_t vec [6];

  always #5 clk = ~clk;

  hog_perf_monitor #(.LEVELS(7), .CNT_W(32), .WINDOW_CYCLES(W), .VERSION(VER)) dut (
    .clk(clk), .rst(rst), .cmd_pio(cmd_pio),
    .hog_input_valid(hog_input_valid), .hog_input_ready(hog_input_ready),
    .hog_out_valid(hog_out_valid), .hog_out_ready(hog_out_ready),
    .switch_out_valid(switch_out_valid), .switch_out_ready(switch_out_ready),
    .status_pio(status_pio), .data_pio(data_pio), .busy(busy)
  );

  // Narrow counters to make saturation reachable
  hog_perf_monitor #(.LEVELS(7), .CNT_W(4), .WINDOW_CYCLES(W), .VERSION(VER)) dut2 (
    .clk(clk), .rst(rst), .cmd_pio(cmd_pio),
    .hog_input_valid(hog_input_valid), .hog_input_ready(hog_input_ready),
    .hog_out_valid(hog_out_valid), .hog_out_ready(hog_out_ready),
    .switch_out_valid(switch_out_valid), .switch_out_ready(switch_out_ready),
    .status_pio(status2), .data_pio(data2), .busy(busy2)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_zero();
    hog_input_valid = 0; hog_input_ready = 0;
    hog_out_valid = '0; hog_out_ready = '0;
    switch_out_valid = 0; switch_out_ready = 0;
  endtask

  task automatic drive(input int i);
    hog_input_valid  = tr_iv[i];
    hog_input_ready  = tr_ir[i];
    hog_out_valid    = tr_hv[i];
    hog_out_ready    = tr_hr[i];
    switch_out_valid = tr_sv[i];
    switch_out_ready = tr_sr[i];
  endtask

  task automatic pulse(input logic [31:0] c);
    cmd_pio = c; step();
    cmd_pio = '0; step();
  endtask

  task automatic build_trace(input int mode, input int ff);
    for (int i = 0; i < N; i++) begin
      tr_iv[i] = 0; tr_ir[i] = 0; tr_sv[i] = 0; tr_sr[i] = 0;
      tr_hv[i] = '0; tr_hr[i] = '0;
      case (mode)
        M_FULL: if (i >= ff) begin tr_iv[i] = 1; tr_ir[i] = 1; end
        M_ALT: if (i >= ff) begin tr_iv[i] = 1; tr_ir[i] = ((i - ff) % 2 == 0); end
        M_SWSTALL: begin
          if (i >= ff) begin tr_iv[i] = 1; tr_ir[i] = 1; end
          tr_sv[i] = 1;
        end
        M_HOG: begin
          tr_iv[i] = 1; tr_ir[i] = 1;
          tr_hv[i] = 7'(1 << (i % 7));
          tr_hr[i] = (i % 3 == 0) ? tr_hv[i] : ~tr_hv[i];
          tr_sv[i] = 1; tr_sr[i] = (i % 2 == 0);
        end
        M_STARVE: begin
          if (i == ff) begin tr_iv[i] = 1; tr_ir[i] = 1; end
          else if (i > ff) tr_ir[i] = 1;
        end
        M_RAND: begin
          tr_iv[i] = ($urandom_range(0, 3) != 0);
          tr_ir[i] = ($urandom_range(0, 2) != 0);
          if (i < 20) begin tr_iv[i] = tr_iv[i] & ($urandom_range(0, 3) == 0); end
          if (i == 20) begin tr_iv[i] = 1; tr_ir[i] = 1; end
          tr_hv[i] = 7'($urandom);
          tr_hr[i] = 7'($urandom);
          tr_sv[i] = 1'($urandom);
          tr_sr[i] = 1'($urandom);
        end
        default: ;
      endcase
    end
  endtask

  // Window = [first accepted input beat, that + W - 1], cut short by a stop; stop before the beat aborts
  task automatic model(input int stop_at, output logic [6:0][31:0] e, output logic [3:0] st);
    int f, last;
    f = -1;
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (tr_iv[i] && tr_ir[i]) begin f = i; break; end
    end
    if (f < 0 && stop_at < 0) begin st = 4'h5; return; end
    if (f < 0 || stop_at <= f && stop_at >= 0) begin st = 4'h0; return; end
    last = f + W - 1;
    if (stop_at >= 0 && stop_at < last) last = stop_at;
    for (int i = f; i <= last; i++) begin
      e[0] += 1;
      e[1] += 32'(tr_iv[i] & tr_ir[i]);
      e[2] += 32'(tr_iv[i] & ~tr_ir[i]);
      e[3] += 32'(tr_ir[i] & ~tr_iv[i]);
      e[4] += 32'(|(tr_hv[i] & tr_hr[i]));
      e[5] += 32'(tr_sv[i] & tr_sr[i]);
      e[6] += 32'(tr_sv[i] & ~tr_sr[i]);
    end
    st = 4'hB;
  endtask

  task automatic run_window(input int stop_at, output logic [3:0] early);
    drive_zero();
    pulse(C_CLEAR);
    pulse(C_START);
    early = '0;
    for (int i = 0; i < N; i++) begin
      drive(i);
      cmd_pio = (i == stop_at - 1) ? C_STOP : 32'h0;
      step();
      if (i == 0) early = status_pio[3:0];
    end
    drive_zero();
    cmd_pio = '0;
  endtask

  task automatic read_all(input string tag, input logic [6:0][31:0] e, input logic [3:0] st,
                          input bit use2);
    logic [31:0] ex, ex2;
    for (int s = 0; s < 8; s++) begin
      cmd_pio = 32'(s << 4);
      step(); step();
      ex  = (s == 7) ? VER : e[s];
      ex2 = (s == 7) ? VER : ((e[s] > 32'd15) ? 32'd15 : e[s]);
      chk($sformatf("%s data sel%0d", tag, s), data_pio, ex);
      if (use2) chk($sformatf("%s sat data sel%0d", tag, s), data2, ex2);
    end
    chk($sformatf("%s status", tag), status_pio, {28'd0, st});
    chk($sformatf("%s busy", tag), 32'(busy), 32'(st[2]));
    if (use2) chk($sformatf("%s sat status", tag), status2, {28'd0, st});
    cmd_pio = '0;
  endtask

  task automatic set_vec(input int k, input int mode, input int ff, input int stop_at,
                         input logic [3:0] early, input logic [3:0] st,
                         input int c0, input int c1, input int c2, input int c3,
                         input int c4, input int c5, input int c6);
    vec[k].mode = mode; vec[k].ff = ff; vec[k].stop_at = stop_at;
    vec[k].early = early; vec[k].st = st;
    vec[k].exp[0] = 32'(c0); vec[k].exp[1] = 32'(c1); vec[k].exp[2] = 32'(c2);
    vec[k].exp[3] = 32'(c3); vec[k].exp[4] = 32'(c4); vec[k].exp[5] = 32'(c5);
    vec[k].exp[6] = 32'(c6);
  endtask

  initial begin
    logic [3:0]       early, st;
    logic [6:0][31:0] e;
    int               stop_at;

    //       mode       ff stop early st     cyc beat stall starve hog obeat ostall
    set_vec(0, M_FULL,    10, -1, 4'h5, 4'hB, 100, 100, 0,  0,  0,  0,  0);
    set_vec(1, M_ALT,      5, -1, 4'h5, 4'hB, 100,  50, 50, 0,  0,  0,  0);
    set_vec(2, M_SWSTALL,  3, 42, 4'h5, 4'hB,  40,  40, 0,  0,  0,  0,  40);
    set_vec(3, M_NONE,     0,  8, 4'h5, 4'h0,   0,   0, 0,  0,  0,  0,  0);
    set_vec(4, M_HOG,      0, -1, 4'h6, 4'hB, 100, 100, 0,  0,  34, 50, 50);
    set_vec(5, M_STARVE,   2, 21, 4'h5, 4'hB,  20,   1, 0,  19, 0,  0,  0);

    rst = 1; cmd_pio = '0; drive_zero();
    step(); step(); step();
    chk("reset status", status_pio, 32'h0);
    chk("reset data", data_pio, 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    rst = 0;
    cmd_pio = 32'h70;
    step(); step();
    chk("reset version", data_pio, VER);
    chk("reset idle status", status_pio, 32'h0);
    cmd_pio = '0;

    for (int k = 0; k < 6; k++) begin
      build_trace(vec[k].mode, vec[k].ff);
      run_window(vec[k].stop_at, early);
      chk($sformatf("vec%0d early status", k), 32'(early), 32'(vec[k].early));
      read_all($sformatf("vec%0d", k), vec[k].exp, vec[k].st, vec[k].stop_at >= 0);
    end

    // Start and clear in the same cycle: clear wins, counters from the last window are wiped
    cmd_pio = C_START | C_CLEAR; step();
    cmd_pio = '0; step();
    chk("start+clear status", status_pio, 32'h0);
    read_all("start+clear", '0, 4'h0, 1'b0);

    // Held start arms once; after an abort the still-held bit must not re-arm
    for (int k = 0; k < 20; k++) begin
      cmd_pio = C_START | ((k == 10) ? C_STOP : 32'h0);
      step();
      if (k == 5) chk("held start armed", status_pio, 32'h5);
    end
    chk("held start idle", status_pio, 32'h0);
    chk("held start busy", 32'(busy), 32'h0);
    cmd_pio = '0; step();

    // Reset in the middle of a running window
    pulse(C_START);
    hog_input_valid = 1; hog_input_ready = 1;
    for (int k = 0; k < 30; k++) step();
    chk("midrun status", status_pio, 32'h6);
    rst = 1; step(); rst = 0;
    chk("midrun reset status", status_pio, 32'h0);
    chk("midrun reset data", data_pio, 32'h0);
    cmd_pio = 32'h10; step(); step();
    chk("midrun reset beats", data_pio, 32'h0);
    drive_zero(); cmd_pio = '0;

    for (int r = 0; r < 8; r++) begin
      build_trace(M_RAND, 0);
      stop_at = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, 130));
      run_window(stop_at, early);
      model(stop_at, e, st);
      read_all($sformatf("rand%0d", r), e, st, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
